// File: rtl/spwm_speed_ramp_ctrl.sv
// Soft-start / speed scheduler for the SPWM generator: slews the NCO frequency
// word toward a target, derives a V/f modulation index and sequences enable/fault.
module spwm_speed_ramp_ctrl #(
    parameter int FW       = 16,
    parameter int MW       = 8,
    parameter int RAMP_DIV = 1000,
    parameter int STEP     = 4,
    parameter int VF_SHIFT = 8,
    parameter int BOOST    = 16
) (
    input  logic          clk_int,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          estop,
    input  logic [FW-1:0] target_freq,
    input  logic [7:0]    vf_gain,
    output logic [FW-1:0] freq_word,
    output logic [MW-1:0] mod_index,
    output logic          pwm_en,
    output logic          at_speed,
    output logic [1:0]    state,
    output logic          fault
);
    typedef enum logic [1:0] {IDLE = 2'd0, SLEW = 2'd1, RUN = 2'd2, DECEL = 2'd3} state_t;

    localparam int PW = $clog2(RAMP_DIV);
    localparam int RW = FW + 9;
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [FW-1:0] STEP_W     = FW'(STEP);
    localparam logic [RW-1:0] MOD_MAX    = {{(RW-MW){1'b0}}, {MW{1'b1}}};

    state_t        state_q, state_d;
    logic [FW-1:0] freq_q, freq_d;
    logic [MW-1:0] mod_q, mod_d;
    logic          pwm_en_q, pwm_en_d;
    logic          fault_q, fault_d;
    logic [PW-1:0] presc_q, presc_d;

    logic          tick;
    logic          up;
    logic          req_start;
    logic [FW-1:0] diff;
    logic [FW-1:0] slew_next;
    logic [FW+7:0] prod;
    logic [RW-1:0] raw;

    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        up        = (target_freq >= freq_q);
        diff      = up ? (target_freq - freq_q) : (freq_q - target_freq);
        // Step never passes the target: the final step lands exactly on it.
        slew_next = (diff <= STEP_W) ? target_freq
                  : (up ? freq_q + STEP_W : freq_q - STEP_W);
        req_start = start && !stop;

        state_d  = state_q;
        freq_d   = freq_q;
        pwm_en_d = pwm_en_q;
        fault_d  = fault_q;
        presc_d  = '0;
        if (state_q == SLEW || state_q == DECEL)
            presc_d = tick ? '0 : presc_q + 1'b1;

        if (estop) begin
            state_d  = IDLE;
            freq_d   = '0;
            pwm_en_d = 1'b0;
            fault_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    freq_d   = '0;
                    pwm_en_d = 1'b0;
                    if (req_start) begin
                        if (fault_q) begin
                            fault_d = 1'b0;
                        end else if (target_freq != '0) begin
                            state_d  = SLEW;
                            pwm_en_d = 1'b1;
                        end
                    end
                end
                SLEW: begin
                    if (stop) begin
                        state_d = DECEL;
                    end else if (tick) begin
                        freq_d = slew_next;
                        if (diff <= STEP_W) state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop || target_freq == '0) state_d = DECEL;
                    else if (target_freq != freq_q) state_d = SLEW;
                end
                DECEL: begin
                    if (req_start && target_freq != '0) begin
                        state_d = SLEW;
                    end else if (tick) begin
                        if (freq_q <= STEP_W) begin
                            freq_d   = '0;
                            state_d  = IDLE;
                            pwm_en_d = 1'b0;
                        end else begin
                            freq_d = freq_q - STEP_W;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Every state entry restarts the ramp interval.
        if (state_d != state_q) presc_d = '0;

        prod  = {8'b0, freq_q} * {{FW{1'b0}}, vf_gain};
        raw   = RW'(BOOST) + RW'(prod >> VF_SHIFT);
        mod_d = '0;
        if (pwm_en_q && !estop)
            mod_d = (raw > MOD_MAX) ? {MW{1'b1}} : raw[MW-1:0];
    end

    always_ff @(posedge clk_int) begin
        if (!reset) begin
            state_q  <= IDLE;
            freq_q   <= '0;
            mod_q    <= '0;
            pwm_en_q <= 1'b0;
            fault_q  <= 1'b0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            mod_q    <= mod_d;
            pwm_en_q <= pwm_en_d;
            fault_q  <= fault_d;
            presc_q  <= presc_d;
        end
    end

    assign freq_word = freq_q;
    assign mod_index = mod_q;
    assign pwm_en    = pwm_en_q;
    assign at_speed  = (state_q == RUN);
    assign state     = state_q;
    assign fault     = fault_q;
endmodule

// File: tb/tb_spwm_speed_ramp_ctrl.sv
// Directed bench for spwm_speed_ramp_ctrl: frequency-word trajectory is
// scoreboarded through a queue, control outputs are checked at fixed edges.
module tb_spwm_speed_ramp_ctrl;
    localparam int FW = 16;
    localparam int MW = 8;

    logic          clk_int = 1'b0;
    logic          reset;
    logic          start, stop, estop;
    logic [FW-1:0] target_freq;
    logic [7:0]    vf_gain;
    logic [FW-1:0] freq_word;
    logic [MW-1:0] mod_index;
    logic          pwm_en, at_speed, fault;
    logic [1:0]    state;

    int n_cmp = 0;
    int n_err = 0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] prev_freq = '0;
    logic [FW-1:0] exp_f;

    spwm_speed_ramp_ctrl #(
        .FW(FW), .MW(MW), .RAMP_DIV(4), .STEP(4), .VF_SHIFT(8), .BOOST(16)
    ) dut (
        .clk_int(clk_int), .reset(reset), .start(start), .stop(stop), .estop(estop),
        .target_freq(target_freq), .vf_gain(vf_gain), .freq_word(freq_word),
        .mod_index(mod_index), .pwm_en(pwm_en), .at_speed(at_speed),
        .state(state), .fault(fault)
    );

    always #5 clk_int = ~clk_int;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_int);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every change of freq_word must match the next expected value in order.
    always @(negedge clk_int) begin
        if (freq_word !== prev_freq) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL freq_unexpected: observed %0d expected no change from %0d",
                       freq_word, prev_freq);
            end else begin
                exp_f = exp_q.pop_front();
                assert (freq_word === exp_f) else begin
                    n_err++;
                    $error("FAIL freq_seq: observed %0d expected %0d", freq_word, exp_f);
                end
            end
            prev_freq = freq_word;
        end
    end

    initial begin
        int guard;
        reset = 1'b0; start = 1'b0; stop = 1'b0; estop = 1'b0;
        target_freq = '0; vf_gain = '0;
        tick(3);
        chk("rst_state", state, 0);
        chk("rst_freq", freq_word, 0);
        chk("rst_mod", mod_index, 0);
        chk("rst_pwm", pwm_en, 0);
        chk("rst_at_speed", at_speed, 0);
        chk("rst_fault", fault, 0);
        reset = 1'b1;
        tick(1);

        // Start ramp to 12
        target_freq = 12; vf_gain = 64; start = 1'b1;
        exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(12);
        tick(1); start = 1'b0;
        chk("t1_pwm_en", pwm_en, 1);
        chk("t1_state_slew", state, 1);
        tick(3);
        chk("t1_freq_hold", freq_word, 0);
        tick(1);
        chk("t1_freq4", freq_word, 4);
        tick(4);
        chk("t1_freq8", freq_word, 8);
        tick(4);
        chk("t1_freq12", freq_word, 12);
        chk("t1_state_run", state, 2);
        chk("t1_at_speed", at_speed, 1);
        chk("t1_mod_lag", mod_index, 18);
        tick(1);
        chk("t1_mod19", mod_index, 19);

        // Retarget down to 6
        target_freq = 6;
        exp_q.push_back(8); exp_q.push_back(6);
        tick(1);
        chk("t2_state_slew", state, 1);
        chk("t2_at_speed_low", at_speed, 0);
        tick(4);
        chk("t2_freq8", freq_word, 8);
        tick(4);
        chk("t2_freq6", freq_word, 6);
        chk("t2_state_run", state, 2);
        chk("t2_at_speed", at_speed, 1);

        // Stop, restart mid-decel, then decelerate to idle
        stop = 1'b1;
        exp_q.push_back(2);
        tick(1); stop = 1'b0;
        chk("t3_state_decel", state, 3);
        tick(4);
        chk("t3_freq2", freq_word, 2);
        target_freq = 12; start = 1'b1;
        exp_q.push_back(6);
        tick(1); start = 1'b0;
        chk("t3_restart_slew", state, 1);
        tick(4);
        chk("t3_freq6", freq_word, 6);
        stop = 1'b1;
        exp_q.push_back(2); exp_q.push_back(0);
        tick(1); stop = 1'b0;
        chk("t3_state_decel2", state, 3);
        tick(8);
        chk("t3_freq0", freq_word, 0);
        chk("t3_state_idle", state, 0);
        chk("t3_pwm_off", pwm_en, 0);
        chk("t3_mod_lag", mod_index, 16);
        tick(1);
        chk("t3_mod0", mod_index, 0);

        // Emergency stop and fault recovery
        target_freq = 12; start = 1'b1;
        exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(0);
        tick(1); start = 1'b0;
        tick(8);
        chk("t4_freq8", freq_word, 8);
        estop = 1'b1;
        tick(1);
        chk("t4_state", state, 0);
        chk("t4_freq", freq_word, 0);
        chk("t4_mod", mod_index, 0);
        chk("t4_pwm", pwm_en, 0);
        chk("t4_fault", fault, 1);
        start = 1'b1;
        tick(1); start = 1'b0;
        chk("t4_start_estop_fault", fault, 1);
        chk("t4_start_estop_state", state, 0);
        estop = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1); start = 1'b0;
        chk("t4_fault_clr", fault, 0);
        chk("t4_clr_state", state, 0);
        chk("t4_clr_pwm", pwm_en, 0);
        start = 1'b1;
        exp_q.push_back(4);
        tick(1); start = 1'b0;
        chk("t4_run_state", state, 1);
        chk("t4_run_pwm", pwm_en, 1);
        tick(4);
        chk("t4_freq4", freq_word, 4);

        // Long ramp to 4095 with max gain: index must saturate
        target_freq = 4095; vf_gain = 255;
        for (int f = 8; f < 4095; f += 4) exp_q.push_back(FW'(f));
        exp_q.push_back(4095);
        guard = 0;
        while (state != 2'd2 && guard < 6000) begin
            tick(1);
            guard++;
        end
        chk("t5_ramp_done", (guard < 6000), 1);
        chk("t5_freq4095", freq_word, 4095);
        tick(1);
        chk("t5_mod_sat", mod_index, 255);

        // Reset mid-slew, then start+stop together in idle
        target_freq = 100;
        exp_q.push_back(4091); exp_q.push_back(0);
        tick(1);
        chk("t6_state_slew", state, 1);
        tick(4);
        chk("t6_freq4091", freq_word, 4091);
        reset = 1'b0;
        tick(1);
        chk("t6_rst_state", state, 0);
        chk("t6_rst_freq", freq_word, 0);
        chk("t6_rst_mod", mod_index, 0);
        chk("t6_rst_pwm", pwm_en, 0);
        chk("t6_rst_at_speed", at_speed, 0);
        reset = 1'b1;
        target_freq = 12; start = 1'b1; stop = 1'b1;
        tick(1); start = 1'b0; stop = 1'b0;
        chk("t6_startstop_state", state, 0);
        chk("t6_startstop_pwm", pwm_en, 0);
        tick(5);
        chk("t6_idle_freq", freq_word, 0);
        chk("t6_exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spwm_speed_ramp_ctrl.md
Name: spwm_speed_ramp_ctrl

Overview:
Soft-start and speed scheduler for the three-phase SPWM generator. Slews the generator's frequency word toward a commanded target at a programmable rate and derives a V/f-proportional modulation index with low-speed boost. Gates the PWM enable and handles start, stop, retarget and emergency-stop sequencing. Sits between the motor command interface and the SPWM datapath (carrier/sine NCO) in top_spwm.

Parameters:
FW, 16, width of frequency word (NCO phase increment)
MW, 8, width of modulation index
RAMP_DIV, 1000, clk_int cycles per ramp step (>=2)
STEP, 4, frequency-word change per ramp step (>=1)
VF_SHIFT, 8, right shift applied to freq_word*vf_gain
BOOST, 16, constant added to the index (low-speed voltage boost)

Ports:
clk_int  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on the next clk_int edge)
start  in  1  single-cycle start/resume request
stop  in  1  single-cycle controlled-stop request
estop  in  1  level emergency stop
target_freq  in  FW  commanded frequency word, sampled live
vf_gain  in  8  V/f slope
freq_word  out  FW  frequency word to SPWM NCO
mod_index  out  MW  amplitude scale to SPWM datapath
pwm_en  out  1  SPWM output enable
at_speed  out  1  high in RUN
state  out  2  IDLE=0, SLEW=1, RUN=2, DECEL=3
fault  out  1  latched estop indication

Behaviour:
- Reset: state IDLE; freq_word, mod_index, pwm_en, at_speed, fault, prescaler all 0.
- Prescaler: counts 0..RAMP_DIV-1 only in SLEW/DECEL; cleared on every state entry; tick = one cycle when count==RAMP_DIV-1, then wraps to 0. First step is RAMP_DIV cycles after state entry.
- IDLE: freq_word=0, pwm_en=0. start && target_freq!=0 && !fault -> SLEW; pwm_en=1 on that edge. start with target 0 ignored.
- SLEW: on tick, d = target_freq - freq_word (signed). |d|<=STEP -> freq_word=target_freq, go RUN; else freq_word += STEP toward target. Works both directions. Retarget mid-slew follows new target immediately.
- RUN: at_speed=1. target_freq!=freq_word -> SLEW next edge (at_speed low). target_freq==0 in RUN -> DECEL.
- stop in SLEW or RUN -> DECEL next edge.
- DECEL: on tick, freq_word<=STEP -> freq_word=0, IDLE, pwm_en=0 same edge; else freq_word -= STEP. start in DECEL (target!=0) -> SLEW from current freq_word.
- start and stop in same cycle: stop wins (IDLE stays IDLE).
- estop high in any state: next edge state IDLE, freq_word=0, mod_index=0, pwm_en=0, fault=1. Priority: reset > estop > stop > start.
- fault: start ignored while fault=1. start with estop=0 clears fault only; stays IDLE; second start needed to run.
- mod_index: registered, one cycle behind freq_word. raw = BOOST + ((freq_word*vf_gain) >> VF_SHIFT), product FW+8 bits unsigned; saturate to 2^MW-1. mod_index = 0 when pwm_en (previous cycle) is 0 or estop asserted.
- freq_word never overshoots target; no wrap below 0 or above 2^FW-1.

Test Plan:
(RAMP_DIV=4, STEP=4, BOOST=16, VF_SHIFT=8.)
1. Release reset, target=12, vf_gain=64, start -> pwm_en=1; freq_word 4,8,12 at cycles 4,8,12 after start; state RUN, at_speed=1; mod_index=19 one cycle after freq_word=12.
2. In RUN, target 12->6 -> SLEW; freq 8 after 4 cycles, 6 after 8, back to RUN; at_speed low during slew.
3. stop at freq 6 -> DECEL; freq 2, then 0; same edge state IDLE, pwm_en=0; mod_index=0 one cycle later. start during DECEL at freq 2 with target 12 -> SLEW, freq 6.
4. estop during SLEW at freq 8 -> next edge all outputs 0, fault=1; start with estop=1 ignored; start with estop=0 clears fault, stays IDLE; next start ramps normally.
5. Saturation: vf_gain=255, target=4095 reached -> mod_index=255 (not wrapped).
6. reset low mid-SLEW -> next edge all outputs 0, IDLE; start+stop same cycle in IDLE -> remains IDLE, pwm_en=0.
